vector_reg_file_sb: RTL and testbench

Parametrised multi-lane vector register file for the SIMD decode stage. It is the successor to the scalar register file and adds:
- per-lane write masking;
- write-to-read bypass;
- an optional hardwired zero register;
- a per-register busy scoreboard that lets decode detect RAW/WAW hazards against in-flight writebacks.

Two combinational read ports, one write (writeback) port, one reserve (issue) port.

---
 rtl/vector_reg_file_sb.sv | 100 ++++++++++
 tb/tb_vector_reg_file_sb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_reg_file_sb.sv
// Multi-lane vector register file: lane-masked writeback, write-to-read bypass, busy scoreboard.
// Reads/hazard are combinational; writes and reservations land on the next edge; rsv_stall makes issue hold and retry.
module vector_reg_file_sb #(
  parameter int LANES    = 4,
  parameter int LANE_W   = 32,
  parameter int REG_QTY  = 8,
  parameter int SEL_BITS = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [SEL_BITS-1:0]       wr_sel,
  input  logic [LANES-1:0]          wr_lane_mask,
  input  logic [LANES*LANE_W-1:0]   wr_data,
  input  logic [SEL_BITS-1:0]       rd_sel1,
  input  logic [SEL_BITS-1:0]       rd_sel2,
  output logic [LANES*LANE_W-1:0]   rd_data1,
  output logic [LANES*LANE_W-1:0]   rd_data2,
  input  logic                      rsv_en,
  input  logic [SEL_BITS-1:0]       rsv_sel,
  output logic                      rsv_stall,
  output logic [REG_QTY-1:0]        busy,
  output logic                      hazard
);
  localparam int W        = LANES * LANE_W;
  localparam int SEL_SPAN = 1 << SEL_BITS;

  logic [W-1:0]        regs [REG_QTY];
  logic [REG_QTY-1:0]  busyQ;
  logic [REG_QTY-1:0]  busyNext;
  logic [SEL_SPAN-1:0] busyPad;
  logic                wrOk;
  logic                rsvOk;

  // Out-of-range selects and the hardwired zero register behave as if absent.
  function automatic logic selOk(input logic [SEL_BITS-1:0] sel);
    return (int'(sel) < REG_QTY) && !((ZERO_REG != 0) && (sel == '0));
  endfunction

  function automatic logic [W-1:0] readPort(input logic [SEL_BITS-1:0] sel);
    logic [W-1:0] d;
    d = '0;
    if (selOk(sel)) begin
      d = regs[sel];
      if ((BYPASS != 0) && wrOk && (wr_sel == sel)) begin
        for (int i = 0; i < LANES; i++) begin
          if (wr_lane_mask[i]) d[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
        end
      end
    end
    return d;
  endfunction

  // Only a full-mask forwarded writeback resolves a pending read.
  function automatic logic readHazard(input logic [SEL_BITS-1:0] sel);
    return busyPad[sel] &&
           !((BYPASS != 0) && wr_en && (wr_sel == sel) && (&wr_lane_mask));
  endfunction

  assign busyPad   = SEL_SPAN'(busyQ);
  assign wrOk      = wr_en && selOk(wr_sel);
  assign rsv_stall = rsv_en && selOk(rsv_sel) && busyPad[rsv_sel] &&
                     !(wr_en && (wr_sel == rsv_sel));
  assign rsvOk     = rsv_en && selOk(rsv_sel) && !rsv_stall;
  assign busy      = busyQ;

  always_comb begin
    rd_data1 = readPort(rd_sel1);
    rd_data2 = readPort(rd_sel2);
    hazard   = readHazard(rd_sel1) || readHazard(rd_sel2);
  end

  // Clear before set so a same-edge reservation of the written register wins.
  always_comb begin
    busyNext = busyQ;
    if (wrOk)  busyNext[wr_sel]  = 1'b0;
    if (rsvOk) busyNext[rsv_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busyQ <= '0;
    end else begin
      busyQ <= busyNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_QTY; r++) regs[r] <= '0;
    end else if (wrOk) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_lane_mask[i]) regs[wr_sel][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: tb/tb_vector_reg_file_sb.sv
// Bench for vector_reg_file_sb: two instances (bypass / zero-register variants) against a behavioural model.
module tb_vector_reg_file_sb;
  localparam int LANES = 4;
  localparam int LANE_W = 32;
  localparam int W = LANES * LANE_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         wrEn;
  logic [2:0]   wrSel;
  logic [3:0]   wrMask;
  logic [W-1:0] wrData;
  logic [2:0]   rdSel1, rdSel2, rsvSel;
  logic         rsvEn;
  logic [W-1:0] aRd1, aRd2, bRd1, bRd2;
  logic         aStall, bStall, aHaz, bHaz;
  logic [7:0]   aBusy, bBusy;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  vector_reg_file_sb dutA (
    .clk(clk), .rst(rst), .wr_en(wrEn), .wr_sel(wrSel), .wr_lane_mask(wrMask), .wr_data(wrData),
    .rd_sel1(rdSel1), .rd_sel2(rdSel2), .rd_data1(aRd1), .rd_data2(aRd2),
    .rsv_en(rsvEn), .rsv_sel(rsvSel), .rsv_stall(aStall), .busy(aBusy), .hazard(aHaz));

  vector_reg_file_sb #(.BYPASS(0), .ZERO_REG(1)) dutB (
    .clk(clk), .rst(rst), .wr_en(wrEn), .wr_sel(wrSel), .wr_lane_mask(wrMask), .wr_data(wrData),
    .rd_sel1(rdSel1), .rd_sel2(rdSel2), .rd_data1(bRd1), .rd_data2(bRd2),
    .rsv_en(rsvEn), .rsv_sel(rsvSel), .rsv_stall(bStall), .busy(bBusy), .hazard(bHaz));

  // Reference model: index 0 = dutA (bypass, no zero reg), 1 = dutB (no bypass, zero reg).
  logic [W-1:0] mReg [2][8];
  logic [7:0]   mBusy [2];
  bit           zr [2] = '{1'b0, 1'b1};
  bit           bp [2] = '{1'b1, 1'b0};

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit absent(int k, logic [2:0] sel);
    return zr[k] && (sel == 3'd0);
  endfunction

  function automatic logic [W-1:0] expRead(int k, logic [2:0] sel);
    logic [W-1:0] d;
    if (absent(k, sel)) return '0;
    d = mReg[k][sel];
    if (bp[k] && wrEn && wrSel == sel)
      for (int i = 0; i < LANES; i++)
        if (wrMask[i]) d[i*LANE_W +: LANE_W] = wrData[i*LANE_W +: LANE_W];
    return d;
  endfunction

  function automatic bit expStall(int k);
    return rsvEn && !absent(k, rsvSel) && mBusy[k][rsvSel] && !(wrEn && wrSel == rsvSel);
  endfunction

  function automatic bit pending(int k, logic [2:0] sel);
    bit resolved;
    resolved = bp[k] && wrEn && (wrSel == sel) && (wrMask == 4'hF);
    return mBusy[k][sel] && !resolved;
  endfunction

  function automatic bit expHaz(int k);
    return pending(k, rdSel1) || pending(k, rdSel2);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mBusy[k] = '0;
      for (int r = 0; r < 8; r++) mReg[k][r] = '0;
    end
  endtask

  task automatic modelEdge();
    bit st;
    for (int k = 0; k < 2; k++) begin
      st = expStall(k);
      if (wrEn && !absent(k, wrSel)) begin
        for (int i = 0; i < LANES; i++)
          if (wrMask[i]) mReg[k][wrSel][i*LANE_W +: LANE_W] = wrData[i*LANE_W +: LANE_W];
        mBusy[k][wrSel] = 1'b0;
      end
      if (rsvEn && !st && !absent(k, rsvSel)) mBusy[k][rsvSel] = 1'b1;
    end
  endtask

  task automatic checkComb();
    chk("a_rd1", aRd1, expRead(0, rdSel1));
    chk("a_rd2", aRd2, expRead(0, rdSel2));
    chk("a_hazard", W'(aHaz), W'(expHaz(0)));
    chk("a_stall", W'(aStall), W'(expStall(0)));
    chk("b_rd1", bRd1, expRead(1, rdSel1));
    chk("b_rd2", bRd2, expRead(1, rdSel2));
    chk("b_hazard", W'(bHaz), W'(expHaz(1)));
    chk("b_stall", W'(bStall), W'(expStall(1)));
  endtask

  task automatic checkBusy();
    chk("a_busy", W'(aBusy), W'(mBusy[0]));
    chk("b_busy", W'(bBusy), W'(mBusy[1]));
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic cycle();
    @(negedge clk);
    checkComb();
    modelEdge();
    @(posedge clk);
    #1;
    checkBusy();
  endtask

  task automatic setIn(input logic we, input logic [2:0] ws, input logic [3:0] m, input logic [W-1:0] d,
                       input logic [2:0] r1, input logic [2:0] r2, input logic re, input logic [2:0] rs);
    wrEn = we; wrSel = ws; wrMask = m; wrData = d;
    rdSel1 = r1; rdSel2 = r2; rsvEn = re; rsvSel = rs;
  endtask

  typedef struct {
    logic         we;
    logic [2:0]   ws;
    logic [3:0]   m;
    logic [W-1:0] d;
    logic [2:0]   r1;
    logic [2:0]   r2;
    logic         re;
    logic [2:0]   rs;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    logic         eHaz;
    logic         eStall;
    logic [7:0]   eBusy;
  } vec_t;

  localparam logic [W-1:0] V3 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [W-1:0] VD = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [W-1:0] VM = 128'h00000004_0000000C_00000002_0000000A;
  localparam logic [W-1:0] VX = 128'h50000003_50000002_50000001_50000000;
  localparam logic [W-1:0] VY = 128'h60000003_60000002_60000001_60000000;
  localparam logic [W-1:0] XY = 128'h50000003_50000002_60000001_60000000;
  localparam logic [W-1:0] Z  = '0;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 3'd3, 4'hF, V3, 3'd3, 3'd2, 1'b0, 3'd0, V3, Z,  1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 3'd0, 4'h0, Z,  3'd3, 3'd2, 1'b0, 3'd0, V3, Z,  1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 3'd3, 4'h5, VD, 3'd3, 3'd3, 1'b0, 3'd0, VM, VM, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 3'd0, 4'h0, Z,  3'd3, 3'd3, 1'b0, 3'd0, VM, VM, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 3'd0, 4'h0, Z,  3'd0, 3'd5, 1'b1, 3'd5, Z,  Z,  1'b0, 1'b0, 8'h20};
    tbl[5]  = '{1'b0, 3'd0, 4'h0, Z,  3'd0, 3'd5, 1'b0, 3'd0, Z,  Z,  1'b1, 1'b0, 8'h20};
    tbl[6]  = '{1'b1, 3'd5, 4'hF, VX, 3'd0, 3'd5, 1'b0, 3'd0, Z,  VX, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 3'd0, 4'h0, Z,  3'd0, 3'd5, 1'b1, 3'd5, Z,  VX, 1'b0, 1'b0, 8'h20};
    tbl[8]  = '{1'b1, 3'd5, 4'h3, VY, 3'd0, 3'd5, 1'b0, 3'd0, Z,  XY, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 3'd0, 4'h0, Z,  3'd0, 3'd0, 1'b1, 3'd5, Z,  Z,  1'b0, 1'b0, 8'h20};
    tbl[10] = '{1'b0, 3'd0, 4'h0, Z,  3'd0, 3'd0, 1'b1, 3'd5, Z,  Z,  1'b0, 1'b1, 8'h20};
    tbl[11] = '{1'b1, 3'd5, 4'h0, VY, 3'd0, 3'd0, 1'b1, 3'd5, Z,  Z,  1'b0, 1'b0, 8'h20};

    rst = 1'b0;
    setIn(1'b0, 3'd0, 4'h0, Z, 3'd0, 3'd0, 1'b0, 3'd0);
    modelReset();
    #12;
    checkComb();
    checkBusy();
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 12; t++) begin
      setIn(tbl[t].we, tbl[t].ws, tbl[t].m, tbl[t].d, tbl[t].r1, tbl[t].r2, tbl[t].re, tbl[t].rs);
      #1;
      chk($sformatf("tbl%0d_rd1", t), aRd1, tbl[t].e1);
      chk($sformatf("tbl%0d_rd2", t), aRd2, tbl[t].e2);
      chk($sformatf("tbl%0d_hazard", t), W'(aHaz), W'(tbl[t].eHaz));
      chk($sformatf("tbl%0d_stall", t), W'(aStall), W'(tbl[t].eStall));
      cycle();
      chk($sformatf("tbl%0d_busy", t), W'(aBusy), W'(tbl[t].eBusy));
    end

    // Zero register: write and reserve register 0 on the zero-register instance.
    setIn(1'b1, 3'd0, 4'hF, {W{1'b1}}, 3'd0, 3'd0, 1'b1, 3'd0);
    #1;
    chk("zr_rd1", bRd1, Z);
    chk("zr_rd2", bRd2, Z);
    chk("zr_stall", W'(bStall), Z);
    chk("zr_hazard", W'(bHaz), Z);
    cycle();
    chk("zr_busy0", W'(bBusy[0]), Z);

    // Fill every register and reserve them all, then reset between edges.
    for (int r = 0; r < 8; r++) begin
      setIn(1'b1, 3'(r), 4'hF, {$urandom(), $urandom(), $urandom(), $urandom() | 32'h1},
            3'(r), 3'd0, 1'b0, 3'd0);
      cycle();
    end
    for (int r = 0; r < 8; r++) begin
      setIn(1'b0, 3'd0, 4'h0, Z, 3'd0, 3'd0, 1'b1, 3'(r));
      cycle();
    end
    chk("pre_rst_busy", W'(aBusy), W'(8'hFF));
    setIn(1'b1, 3'd1, 4'hF, {W{1'b1}}, 3'd2, 3'd3, 1'b0, 3'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_a_busy", W'(aBusy), Z);
    chk("rst_b_busy", W'(bBusy), Z);
    chk("rst_a_rd1", aRd1, Z);
    chk("rst_a_rd2", aRd2, Z);
    chk("rst_b_rd1", bRd1, Z);
    chk("rst_a_hazard", W'(aHaz), Z);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    setIn(1'b0, 3'd0, 4'h0, Z, 3'd1, 3'd1, 1'b0, 3'd0);
    #1;
    chk("rst_write_lost", aRd1, Z);
    cycle();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wrEn   = ($urandom_range(0, 9) < 4);
      wrSel  = 3'($urandom_range(0, 7));
      wrMask = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      wrData = {$urandom(), $urandom(), $urandom(), $urandom()};
      rdSel1 = ($urandom_range(0, 2) == 0) ? wrSel : 3'($urandom_range(0, 7));
      rdSel2 = ($urandom_range(0, 2) == 0) ? wrSel : 3'($urandom_range(0, 7));
      rsvEn  = ($urandom_range(0, 1) == 1);
      rsvSel = ($urandom_range(0, 3) == 0) ? wrSel : 3'($urandom_range(0, 7));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
